// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: ALU opcodes, arbiter FSM states and
// opcode legality helper.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        SLL   = 4'd2,
        SLT   = 4'd3,
        SLTU  = 4'd4,
        XOR   = 4'd5,
        SRL   = 4'd6,
        SRA   = 4'd7,
        OR    = 4'd8,
        AND   = 4'd9,
        LUI   = 4'd10,
        AUIPC = 4'd11
    } alu_op_t;

    localparam logic [3:0] ALU_OP_LAST = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Encodings above the last defined opcode are passed through but flagged.
    function automatic logic op_is_illegal(input logic [3:0] op);
        return op > ALU_OP_LAST;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward,
// with wrap, starting one above the last winner.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any
);

    int cand;

    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between NUM_REQ requesters.
// Optional performance counters are enabled with `define ALU_ARB_PERF_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]  req_op,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [3:0]            alu_op,
    input  logic [31:0]           alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_lt,
    input  logic                  alu_ltu,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_lt,
    output logic                  rsp_ltu,
    output logic                  rsp_illegal
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]           perf_ops,
    output logic [31:0]           perf_stall
`endif
);

    arb_state_t         state, state_next;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic               can_accept;
    logic               accept;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [3:0]         op_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // A new request can land while idle, or while the current response drains.
    assign can_accept = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign accept     = can_accept && grant_any;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = accept ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = can_accept ? grant : '0;
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_lt      <= 1'b0;
            rsp_ltu     <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= req_a[32*grant_idx +: 32];
                b_q  <= req_b[32*grant_idx +: 32];
                op_q <= req_op[4*grant_idx +: 4];
                id_q <= grant_idx;
                ptr  <= grant_idx;
            end
            if (state == EXEC) begin
                rsp_result  <= alu_result;
                rsp_zero    <= alu_zero;
                rsp_lt      <= alu_lt;
                rsp_ltu     <= alu_ltu;
                rsp_illegal <= op_is_illegal(op_q);
            end
        end
    end

    // ALU inputs come only from registers, so they hold between operations.
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;
    assign rsp_id = id_q;

`ifdef ALU_ARB_PERF_EN
    logic stall;
    assign stall = (|req_valid) && !(|req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (accept && (perf_ops != 32'hFFFF_FFFF))  perf_ops   <= perf_ops + 32'd1;
            if (stall && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the alu_* port.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N*4-1:0]  req_op = '0;
    logic [31:0]     alu_a, alu_b, alu_result;
    logic [3:0]      alu_op;
    logic            alu_zero, alu_lt, alu_ltu;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [0:0]      rsp_id;
    logic [31:0]     rsp_result;
    logic            rsp_zero, rsp_lt, rsp_ltu, rsp_illegal;
`ifdef ALU_ARB_PERF_EN
    logic [31:0]     perf_ops, perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_lt      (alu_lt),
        .alu_ltu     (alu_ltu),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_lt      (rsp_lt),
        .rsp_ltu     (rsp_ltu),
        .rsp_illegal (rsp_illegal)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_ops    (perf_ops),
        .perf_stall  (perf_stall)
`endif
    );

    // Behavioural single-cycle ALU; undefined opcodes return 0.
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a << alu_b[4:0];
            4'd3:    alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'd4:    alu_result = {31'b0, alu_a < alu_b};
            4'd5:    alu_result = alu_a ^ alu_b;
            4'd6:    alu_result = alu_a >> alu_b[4:0];
            4'd7:    alu_result = $signed(alu_a) >>> alu_b[4:0];
            4'd8:    alu_result = alu_a | alu_b;
            4'd9:    alu_result = alu_a & alu_b;
            4'd10:   alu_result = alu_b;
            4'd11:   alu_result = alu_a + alu_b;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
        alu_lt   = $signed(alu_a) < $signed(alu_b);
        alu_ltu  = alu_a < alu_b;
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[4*i +: 4]  = op;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if ({alu_a, alu_b, alu_op} !== 68'd0) begin errors++; $display("FAIL reset_alu: got %h/%h/%h expected 0", alu_a, alu_b, alu_op); end
        checks++; if ({rsp_result, rsp_id, rsp_illegal} !== 34'd0) begin errors++; $display("FAIL reset_rsp: got %h id %b ill %b expected 0", rsp_result, rsp_id, rsp_illegal); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        set_req(0, 32'd5, 32'd7, SUB); req_valid = 2'b01; rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_exec_valid: got %b expected 0", rsp_valid); end
        checks++; if ({alu_a, alu_b, alu_op} !== {32'd5, 32'd7, 4'd1}) begin errors++; $display("FAIL single_alu_drive: got %h/%h/%h expected 5/7/1", alu_a, alu_b, alu_op); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b expected 0", rsp_id); end
        checks++; if (rsp_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL single_result: got %h expected fffffffe", rsp_result); end
        checks++; if ({rsp_zero, rsp_lt, rsp_ltu, rsp_illegal} !== 4'b0110) begin errors++; $display("FAIL single_flags: got %b expected 0110", {rsp_zero, rsp_lt, rsp_ltu, rsp_illegal}); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_contention();
        logic [31:0] exp_res [2];
        logic [N-1:0] exp_rdy;
        exp_res[0] = 32'd3;
        exp_res[1] = 32'd30;
        apply_reset();
        @(negedge clk);
        set_req(0, 32'd1, 32'd2, ADD); set_req(1, 32'd10, 32'd20, ADD);
        req_valid = 2'b11; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cont_first_grant: got %b expected 01", req_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++; if ({req_ready, rsp_valid} !== 3'b000) begin errors++; $display("FAIL cont_exec_%0d: got ready %b valid %b expected 00/0", k, req_ready, rsp_valid); end
            @(negedge clk);
            if (k == 3) req_valid = 2'b00;
            #1;
            exp_rdy = (k == 3) ? 2'b00 : (((k + 1) % 2 == 0) ? 2'b01 : 2'b10);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL cont_valid_%0d: got %b expected 1", k, rsp_valid); end
            checks++; if (rsp_id !== 1'(k % 2)) begin errors++; $display("FAIL cont_id_%0d: got %b expected %0d", k, rsp_id, k % 2); end
            checks++; if (rsp_result !== exp_res[k % 2]) begin errors++; $display("FAIL cont_result_%0d: got %h expected %h", k, rsp_result, exp_res[k % 2]); end
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL cont_next_grant_%0d: got %b expected %b", k, req_ready, exp_rdy); end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL cont_idle: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        set_req(0, 32'd3, 32'd4, ADD); set_req(1, 32'd9, 32'd9, ADD);
        req_valid = 2'b01; rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_ready: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_exec_ready: got %b expected 00", req_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++; if ({rsp_valid, rsp_result, req_ready} !== {1'b1, 32'd7, 2'b00}) begin errors++; $display("FAIL bp_hold_%0d: got valid %b result %h ready %b expected 1/7/00", c, rsp_valid, rsp_result, req_ready); end
        end
        req_valid = 2'b00; rsp_ready = 1'b1;
        #1;
        checks++; if ({rsp_valid, rsp_result} !== {1'b1, 32'd7}) begin errors++; $display("FAIL bp_release: got %b/%h expected 1/7", rsp_valid, rsp_result); end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_done: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        set_req(1, 32'd123, 32'd456, 4'b1110); req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL ill_ready: got %b expected 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++; if (alu_op !== 4'b1110) begin errors++; $display("FAIL ill_forward: got %b expected 1110", alu_op); end
        @(negedge clk);
        #1;
        checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL ill_rsp: got valid %b id %b result %h expected 1/1/0", rsp_valid, rsp_id, rsp_result); end
        checks++; if ({rsp_zero, rsp_illegal} !== 2'b11) begin errors++; $display("FAIL ill_flags: got zero %b illegal %b expected 1/1", rsp_zero, rsp_illegal); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        set_req(0, 32'h8000_0000, 32'd4, SRA); req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL arst_ready: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++; if (alu_op !== 4'd7) begin errors++; $display("FAIL arst_exec_op: got %h expected 7", alu_op); end
        rst_n = 1'b0;
        #1;
        checks++; if ({rsp_valid, req_ready, alu_a} !== 35'd0) begin errors++; $display("FAIL arst_immediate: got valid %b ready %b alu_a %h expected 0", rsp_valid, req_ready, alu_a); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL arst_no_rsp_%0d: got %b expected 0", c, rsp_valid); end
        end
        set_req(1, 32'd1, 32'd1, ADD); req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL arst_first_grant: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00; rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'hF800_0000}) begin errors++; $display("FAIL arst_sra: got valid %b id %b result %h expected 1/0/f8000000", rsp_valid, rsp_id, rsp_result); end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL arst_drain: got %b expected 0", rsp_valid); end
    endtask

`ifdef ALU_ARB_PERF_EN
    task automatic test_perf();
        logic [N-1:0] pattern [9];
        pattern = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        apply_reset();
        #1;
        checks++; if ({perf_ops, perf_stall} !== 64'd0) begin errors++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", perf_ops, perf_stall); end
        rsp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            req_valid = pattern[c];
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++; if (perf_ops !== 32'd3) begin errors++; $display("FAIL perf_ops: got %0d expected 3", perf_ops); end
        checks++; if (perf_stall !== 32'd2) begin errors++; $display("FAIL perf_stall: got %0d expected 2", perf_stall); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_async_reset();
`ifdef ALU_ARB_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
